// File: rtl/multi_bitseq_pkg.sv
// multi_bitseq_pkg: shared play-mode encoding and sizing helpers for the step sequencer
package multi_bitseq_pkg;
  typedef enum logic [1:0] {MODE_FWD = 2'b00, MODE_REV = 2'b01, MODE_PING = 2'b10} mode_e;
  function automatic int step_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int clamp_steps(input int s, input int depth);
    return (s == 0 || s > depth) ? depth : s;
  endfunction
endpackage

// File: rtl/bitseq_lane.sv
// bitseq_lane: one pattern lane - step pointer, ping-pong direction, arm flag and trigger pulse stretcher
module bitseq_lane import multi_bitseq_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int PW_W = 8,
  localparam int SW = step_width(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic step,
  input  logic [1:0] mode,
  input  logic [PW_W-1:0] pulse_w,
  input  logic [DEPTH-1:0] pat,
  input  logic [SW-1:0] steps,
  output logic trig,
  output logic [SW-1:0] pos
);
  logic [SW-1:0] s, last, inc, dec, nxt_pos;
  logic [PW_W-1:0] cnt, pw;
  logic [DEPTH-1:0] sh;
  logic [1:0] mode_q;
  logic dir, armed, rev, ping, up, go_up, nxt_dir, fire;
  always_comb begin
    s = SW'(clamp_steps(int'(steps), DEPTH));
    last = s - SW'(1);
    inc = pos + SW'(1);
    dec = pos - SW'(1);
    rev = mode == MODE_REV;
    ping = mode == MODE_PING;
    up = dir | (mode != mode_q);
    go_up = (up && inc < s) || pos == '0;
    nxt_pos = armed ? (rev ? last : '0) :
              rev ? ((pos == '0 || pos >= s) ? last : dec) :
              ping ? ((pos >= s || s == SW'(1)) ? '0 : (go_up ? inc : dec)) :
              (inc >= s ? '0 : inc);
    nxt_dir = (!ping || armed || pos >= s || s == SW'(1)) ? 1'b1 :
              go_up ? (nxt_pos != last) : (nxt_pos == '0);
    sh = pat << nxt_pos;
    fire = sh[DEPTH-1];
    pw = (pulse_w == '0) ? PW_W'(1) : pulse_w;
  end
  // a fire during an active pulse reloads the counter so the trigger stays high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos <= '0;
      dir <= 1'b1;
      armed <= 1'b1;
      cnt <= '0;
      mode_q <= '0;
    end else begin
      mode_q <= mode;
      if (restart) begin
        dir <= 1'b1;
        armed <= 1'b1;
        cnt <= '0;
      end else if (step) begin
        pos <= nxt_pos;
        dir <= nxt_dir;
        armed <= 1'b0;
        cnt <= fire ? pw : cnt - PW_W'(cnt != '0);
      end else begin
        dir <= up;
        cnt <= cnt - PW_W'(cnt != '0);
      end
    end
  assign trig = cnt != '0;
endmodule

// File: rtl/multi_bitseq.sv
// multi_bitseq: shared step-rate divider driving CHANNELS bit-pattern trigger lanes
module multi_bitseq import multi_bitseq_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 16,
  parameter int PW_W = 8,
  localparam int SW = step_width(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic restart,
  input  logic [23:0] len,
  input  logic [1:0] mode,
  input  logic [PW_W-1:0] pulse_w,
  input  logic [CHANNELS*DEPTH-1:0] seq,
  input  logic [CHANNELS*SW-1:0] steps,
  output logic [CHANNELS-1:0] trig_out,
  output logic step_tick,
  output logic [CHANNELS*SW-1:0] pos
);
  logic [23:0] cnt, lm1;
  assign lm1 = (len == '0) ? '0 : len - 24'd1;
  // >= rather than == so a shortened period wraps at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      step_tick <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      step_tick <= 1'b0;
    end else if (ena) begin
      cnt <= (cnt >= lm1) ? '0 : cnt + 24'd1;
      step_tick <= cnt >= lm1;
    end else
      step_tick <= 1'b0;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    bitseq_lane #(.DEPTH(DEPTH), .PW_W(PW_W)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .restart(restart),
      .step(step_tick),
      .mode(mode),
      .pulse_w(pulse_w),
      .pat(seq[c*DEPTH +: DEPTH]),
      .steps(steps[c*SW +: SW]),
      .trig(trig_out[c]),
      .pos(pos[c*SW +: SW])
    );
  end
endmodule

// File: tb/tb_multi_bitseq.sv
// tb_multi_bitseq: randomized scoreboard bench for multi_bitseq against a behavioural model
module tb_multi_bitseq;
  localparam int CH = 4, D = 16, SW = 5, PWW = 8;
  logic clk = 0, rst_n = 0, ena = 0, restart = 0;
  logic [23:0] len = 24'd4;
  logic [1:0] mode = 2'b00;
  logic [PWW-1:0] pulse_w = '0;
  logic [CH*D-1:0] seq = '0;
  logic [CH*SW-1:0] steps = '0;
  logic [CH-1:0] trig_out;
  logic step_tick;
  logic [CH*SW-1:0] pos;
  int total = 0, bad = 0;
  typedef struct {logic tick; logic [CH-1:0] trig; logic [CH*SW-1:0] pos;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int m_cnt, m_pos[CH], m_pc[CH];
  bit m_tick, m_down[CH], m_armed[CH];
  logic [1:0] m_prev;

  multi_bitseq #(.CHANNELS(CH), .DEPTH(D), .PW_W(PWW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .restart(restart), .len(len), .mode(mode),
    .pulse_w(pulse_w), .seq(seq), .steps(steps), .trig_out(trig_out),
    .step_tick(step_tick), .pos(pos)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_cnt = 0;
    m_tick = 0;
    m_prev = 2'b00;
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0;
      m_down[c] = 0;
      m_armed[c] = 1;
      m_pc[c] = 0;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.tick = m_tick;
    for (int c = 0; c < CH; c++) begin
      e.trig[c] = m_pc[c] > 0;
      e.pos[c*SW +: SW] = SW'(m_pos[c]);
    end
    return e;
  endfunction

  // ping-pong modelled as a phase walking round a cycle of 2S-2 positions
  task automatic step_model();
    int l, s, p, ph, pw, md;
    bit old;
    l = (len == 0) ? 1 : int'(len);
    pw = (pulse_w == 0) ? 1 : int'(pulse_w);
    md = (mode == 2'b11) ? 0 : int'(mode);
    old = m_tick;
    if (restart) begin
      m_cnt = 0;
      m_tick = 0;
      for (int c = 0; c < CH; c++) begin
        m_armed[c] = 1;
        m_down[c] = 0;
        m_pc[c] = 0;
      end
    end else begin
      if (ena) begin
        m_tick = m_cnt >= l - 1;
        m_cnt = m_tick ? 0 : m_cnt + 1;
      end else m_tick = 0;
      for (int c = 0; c < CH; c++) begin
        if (mode != m_prev) m_down[c] = 0;
        if (old) begin
          s = int'(steps[c*SW +: SW]);
          if (s == 0 || s > D) s = D;
          if (m_armed[c]) begin
            p = (md == 1) ? s - 1 : 0;
            m_armed[c] = 0;
            m_down[c] = 0;
          end else if (md == 0) p = (m_pos[c] + 1 >= s) ? 0 : m_pos[c] + 1;
          else if (md == 1) p = (m_pos[c] == 0 || m_pos[c] >= s) ? s - 1 : m_pos[c] - 1;
          else if (m_pos[c] >= s || s == 1) begin
            p = 0;
            m_down[c] = 0;
          end else begin
            ph = m_down[c] ? 2*s - 2 - m_pos[c] : m_pos[c];
            ph = (ph + 1) % (2*s - 2);
            p = (ph < s) ? ph : 2*s - 2 - ph;
            m_down[c] = ph >= s;
          end
          m_pos[c] = p;
          m_pc[c] = seq[c*D + D - 1 - p] ? pw : (m_pc[c] > 0 ? m_pc[c] - 1 : 0);
        end else if (m_pc[c] > 0) m_pc[c]--;
      end
    end
    m_prev = mode;
  endtask

  initial m_reset();

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else step_model();
    sb.push_back(snap());
  end

  always @(negedge rst_n) begin
    m_reset();
    sb.delete();
    sb.push_back(snap());
  end

  always @(negedge clk)
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      total++;
      if (step_tick !== e_mon.tick || trig_out !== e_mon.trig || pos !== e_mon.pos) begin
        bad++;
        $display("FAIL outputs t=%0t tick got %b want %b trig got %b want %b pos got %h want %h",
                 $time, step_tick, e_mon.tick, trig_out, e_mon.trig, pos, e_mon.pos);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int c, input logic [D-1:0] p, input int st);
    seq[c*D +: D] = p;
    steps[c*SW +: SW] = SW'(st);
  endtask

  initial begin
    bit hit;
    set_lane(0, 16'h8001, 0);
    set_lane(1, 16'hA000, 4);
    set_lane(2, 16'h1000, 4);
    set_lane(3, 16'h5A5A, 7);
    cyc(3);
    rst_n = 1;
    ena = 1;
    cyc(140);
    mode = 2'b01;
    cyc(80);
    mode = 2'b10;
    cyc(100);
    mode = 2'b00;
    pulse_w = 8'd10;
    seq = '1;
    cyc(60);
    len = 24'd0;
    cyc(20);
    len = 24'd4;
    pulse_w = 8'd0;
    set_lane(0, 16'h8001, 0);
    set_lane(1, 16'hA000, 4);
    set_lane(2, 16'h1000, 4);
    set_lane(3, 16'h5A5A, 7);
    cyc(30);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (step_tick) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL restart_align step_tick got 0 want 1 within 20 cycles");
    end
    restart = 1;
    cyc(1);
    restart = 0;
    cyc(20);
    pulse_w = 8'd20;
    seq = '1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (trig_out[0]) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL pulse_wait trig_out[0] got 0 want 1 within 20 cycles");
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1 total++;
    if (trig_out !== '0 || pos !== '0 || step_tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset trig got %b pos got %h tick got %b want all zero", trig_out, pos, step_tick);
    end
    cyc(2);
    rst_n = 1;
    pulse_w = 8'd0;
    len = 24'd2;
    set_lane(0, 16'h0020, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (pos[SW-1:0] == 5'd10) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL shrink_wait pos[0] got %0d want 10 within 100 cycles", pos[SW-1:0]);
    end
    steps[SW-1:0] = 5'd4;
    cyc(10);
    pulse_w = 8'd15;
    seq = '1;
    cyc(10);
    ena = 0;
    cyc(20);
    ena = 1;
    cyc(10);
    for (int k = 0; k < 25; k++) begin
      len = 24'($urandom_range(0, 5));
      mode = 2'($urandom_range(0, 3));
      pulse_w = PWW'($urandom_range(0, 6));
      seq = {$urandom, $urandom};
      steps = (CH*SW)'($urandom);
      restart = 1;
      cyc(1);
      restart = 0;
      for (int i = 0; i < 40; i++) begin
        ena = $urandom_range(0, 9) != 0;
        if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) seq[$urandom_range(0, CH*D-1)] ^= 1'b1;
        cyc(1);
      end
    end
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_bitseq.md
Name: multi_bitseq

Overview:
Multi-channel, parametrised bit-pattern step sequencer generating trigger pulses for the synth voices.
- One shared step-rate divider drives CHANNELS independent pattern lanes.
- Each lane has its own pattern and loop length; lanes share a global play mode (forward/reverse/ping-pong) and a programmable pulse width.
- Fully synchronous to clk: no derived clocks. Sits between the control registers and the voice/envelope triggers.

Parameters:
CHANNELS, 4, number of pattern lanes
DEPTH, 16, steps per pattern (>=2)
PW_W, 8, width of pulse-width control
SW (localparam), $clog2(DEPTH+1), width of per-lane step-count field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  run enable; low freezes divider and step pointers
restart  in  1  synchronous restart of divider and all lanes
len  in  24  divider period in clk cycles (0 treated as 1)
mode  in  2  00 forward, 01 reverse, 10 ping-pong, 11 = forward
pulse_w  in  PW_W  trigger high time in clk cycles (0 treated as 1)
seq  in  CHANNELS*DEPTH  patterns; lane c = seq[c*DEPTH +: DEPTH]; step 0 = MSB of lane
steps  in  CHANNELS*SW  per-lane loop length; 0 or >DEPTH means DEPTH
trig_out  out  CHANNELS  per-lane trigger pulses
step_tick  out  1  one-cycle strobe per step
pos  out  CHANNELS*SW  per-lane currently played step index

Behaviour:
- Reset (async, rst_n=0): counter=0, step_tick=0, trig_out=0, pos=0, ping-pong direction=up, all lanes armed. Takes effect immediately, including mid-pulse.
- Divider, when ena=1:
  - Counter increments each clk.
  - At counter==L-1 (L = max(len,1)): counter wraps to 0 and step_tick is registered high for exactly one cycle.
  - With ena=0, counter holds and step_tick=0.
  - If len changes so that counter >= L-1, the divider wraps on the next enabled cycle.
- Lane step, on each cycle with step_tick=1:
  - Effective length S = steps field, clamped: 0 or >DEPTH gives DEPTH.
  - Armed lane: plays its start position without advancing, then disarms. Start position is 0 for forward and ping-pong, S-1 for reverse.
  - Forward: pos = (pos+1 >= S) ? 0 : pos+1.
  - Reverse: pos = (pos==0 || pos >= S) ? S-1 : pos-1.
  - Ping-pong: bounce at 0 and S-1 without repeating endpoints (S=4 gives 0,1,2,3,2,1,0,1…). S==1 holds at 0.
  - Ping-pong with pos >= S: pos=0, dir=up.
  - Forward with pos >= S (length shrunk): pos=0.
- Trigger:
  - When a lane plays step p, it fires if lane bit (DEPTH-1-p) is 1.
  - Patterns are sampled live at the play edge.
  - trig_out[c] rises on the clk edge after step_tick; latency from divider wrap is 2 edges.
  - A firing lane stays high for max(pulse_w,1) cycles. A fire during an active pulse reloads the count, so the output stays continuously high.
- Pulse counters keep expiring while ena=0.
- restart=1:
  - Counter=0, step_tick=0, trig_out=0, all lanes re-armed, dir=up.
  - Restart has priority over a coincident step_tick; that step is dropped.
- mode changes take effect at the next step. On a mode change, ping-pong dir resets to up.
- pos output shows the last played step: 0 after reset.

Decomposition:
- Package multi_bitseq_pkg holds:
  - mode_e enum: MODE_FWD, MODE_REV, MODE_PING.
  - Function clamp_steps(steps, DEPTH).
  - Function for the step-width calculation.
- Sub-module bitseq_lane, one instance per channel: pointer, direction, armed flag, pulse counter, trig output.
- The top level holds the divider, restart fan-out and the generate loop over lanes.

Test Plan:
1. len=4, pulse_w=0, mode=fwd, lane0 seq=16'h8001, steps=0 -> step_tick every 4 cycles; trig_out[0] one cycle on steps 0 and 15; pattern period 64 cycles.
2. mode=rev, lane1 steps=4, seq=16'hA000 (steps 0,2) -> played order 3,2,1,0,3…; fires on ticks 2 and 4 of every 4.
3. mode=ping, lane2 steps=4, seq=16'h1000 (step 3) -> pos 0,1,2,3,2,1,0,1…; fires once every 6 ticks.
4. len=4, pulse_w=10, seq=16'hFFFF -> trig_out held continuously high by retrigger. Then len=0 -> step_tick every enabled cycle.
5. restart coincident with step_tick mid-pattern -> no fire that cycle; next tick plays step 0. rst_n low mid-pulse -> trig_out drops asynchronously.
6. steps 16->4 while pos=10 (fwd) -> next tick pos=0. ena low 20 cycles -> counter and pos frozen, active pulse still expires.
